// File: rtl/sm83_alu_seq.sv
// Multi-cycle SM83-style ALU: processes a WORD_SIZE-bit operation as ALU_WIDTH-bit slice
// passes, LSB slice first, rippling carry through a register between passes.
module sm83_alu_seq #(
    parameter int unsigned ALU_WIDTH = 4,
    parameter int unsigned WORD_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [2:0]           op,
    input  logic [WORD_SIZE-1:0] a,
    input  logic [WORD_SIZE-1:0] b,
    input  logic                 carry_in,
    output logic                 ready,
    output logic                 valid,
    output logic [WORD_SIZE-1:0] result,
    output logic                 flag_z,
    output logic                 flag_n,
    output logic                 flag_h,
    output logic                 flag_c
);
    localparam int unsigned PASSES = WORD_SIZE / ALU_WIDTH;
    localparam int unsigned CntW   = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [CntW-1:0] LastPass = CntW'(PASSES - 1);

    localparam logic [2:0] OpAdd = 3'd0;
    localparam logic [2:0] OpAdc = 3'd1;
    localparam logic [2:0] OpSub = 3'd2;
    localparam logic [2:0] OpSbc = 3'd3;
    localparam logic [2:0] OpAnd = 3'd4;
    localparam logic [2:0] OpXor = 3'd5;
    localparam logic [2:0] OpOr  = 3'd6;
    localparam logic [2:0] OpCp  = 3'd7;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e               state_q;
    logic [WORD_SIZE-1:0] a_q;
    logic [WORD_SIZE-1:0] b_q;
    logic [WORD_SIZE-1:0] acc_q;
    logic [2:0]           op_q;
    logic                 carry_q;
    logic                 raw_h_q;
    logic [CntW-1:0]      cnt_q;

    logic                 is_sub;
    logic [ALU_WIDTH-1:0] slice_a;
    logic [ALU_WIDTH-1:0] slice_b;
    logic [ALU_WIDTH:0]   slice_sum;
    logic [ALU_WIDTH-1:0] slice_res;
    logic [WORD_SIZE-1:0] full_res;
    logic [WORD_SIZE-1:0] a_rot;
    logic                 eff_carry;
    logic                 n_d, h_d, c_d;

    assign ready = (state_q != StRun);

    always_comb begin
        is_sub    = (op_q == OpSub) || (op_q == OpSbc) || (op_q == OpCp);
        slice_a   = a_q[ALU_WIDTH-1:0];
        slice_b   = b_q[ALU_WIDTH-1:0] ^ {ALU_WIDTH{is_sub}};
        slice_sum = {1'b0, slice_a} + {1'b0, slice_b} + {{ALU_WIDTH{1'b0}}, carry_q};
        case (op_q)
            OpAnd:   slice_res = a_q[ALU_WIDTH-1:0] & b_q[ALU_WIDTH-1:0];
            OpXor:   slice_res = a_q[ALU_WIDTH-1:0] ^ b_q[ALU_WIDTH-1:0];
            OpOr:    slice_res = a_q[ALU_WIDTH-1:0] | b_q[ALU_WIDTH-1:0];
            default: slice_res = slice_sum[ALU_WIDTH-1:0];
        endcase
        // Slices enter at the top of acc_q, so after the last pass they sit in order.
        full_res = {slice_res, acc_q[WORD_SIZE-1:ALU_WIDTH]};
        // a_q rotates one slice per pass; one more rotation restores the operand for CP.
        a_rot    = {a_q[ALU_WIDTH-1:0], a_q[WORD_SIZE-1:ALU_WIDTH]};
    end

    always_comb begin
        case (op)
            OpAdc:       eff_carry = carry_in;
            OpSub, OpCp: eff_carry = 1'b1;
            OpSbc:       eff_carry = ~carry_in;
            default:     eff_carry = 1'b0;
        endcase
    end

    always_comb begin
        n_d = 1'b0;
        h_d = 1'b0;
        c_d = 1'b0;
        case (op_q)
            OpAdd, OpAdc: begin
                h_d = raw_h_q;
                c_d = slice_sum[ALU_WIDTH];
            end
            OpSub, OpSbc, OpCp: begin
                n_d = 1'b1;
                h_d = ~raw_h_q;
                c_d = ~slice_sum[ALU_WIDTH];
            end
            OpAnd:   h_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            op_q    <= OpAdd;
            carry_q <= 1'b0;
            raw_h_q <= 1'b0;
            cnt_q   <= '0;
            valid   <= 1'b0;
            result  <= '0;
            flag_z  <= 1'b0;
            flag_n  <= 1'b0;
            flag_h  <= 1'b0;
            flag_c  <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        op_q    <= op;
                        carry_q <= eff_carry;
                        cnt_q   <= '0;
                        state_q <= StRun;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    a_q     <= a_rot;
                    b_q     <= b_q >> ALU_WIDTH;
                    acc_q   <= full_res;
                    carry_q <= slice_sum[ALU_WIDTH];
                    cnt_q   <= cnt_q + CntW'(1);
                    if (cnt_q == '0) raw_h_q <= slice_sum[ALU_WIDTH];
                    if (cnt_q == LastPass) begin
                        state_q <= StDone;
                        valid   <= 1'b1;
                        result  <= (op_q == OpCp) ? a_rot : full_res;
                        flag_z  <= (full_res == '0);
                        flag_n  <= n_d;
                        flag_h  <= h_d;
                        flag_c  <= c_d;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_sm83_alu_seq.sv
// Directed bench for sm83_alu_seq: an 8/4 instance for the main vectors and a 16/4
// instance for the wide-word latency and carry case.
module tb_sm83_alu_seq;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  op = 3'd0;
    logic        carry_in = 1'b0;

    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        ready8, valid8, z8, n8, h8, c8;
    logic [7:0]  result8;

    logic        start16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        ready16, valid16, z16, n16, h16, c16;
    logic [15:0] result16;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    sm83_alu_seq #(.ALU_WIDTH(4), .WORD_SIZE(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op), .a(a8), .b(b8),
        .carry_in(carry_in), .ready(ready8), .valid(valid8), .result(result8),
        .flag_z(z8), .flag_n(n8), .flag_h(h8), .flag_c(c8)
    );

    sm83_alu_seq #(.ALU_WIDTH(4), .WORD_SIZE(16)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .op(op), .a(a16), .b(b16),
        .carry_in(carry_in), .ready(ready16), .valid(valid16), .result(result16),
        .flag_z(z16), .flag_n(n16), .flag_h(h16), .flag_c(c16)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One 8-bit op: accept, two passes, valid pulse, back to idle.
    task automatic run8(input string tag, input logic [2:0] o, input logic [7:0] av,
                        input logic [7:0] bv, input logic cin, input logic [7:0] er,
                        input logic [3:0] eznhc);
        op = o; a8 = av; b8 = bv; carry_in = cin; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        check({tag, "_ready_run"}, ready8, 0);
        tick();
        check({tag, "_valid_early"}, valid8, 0);
        check({tag, "_ready_run2"}, ready8, 0);
        tick();
        check({tag, "_valid"}, valid8, 1);
        check({tag, "_res"}, result8, er);
        check({tag, "_znhc"}, {z8, n8, h8, c8}, eznhc);
        check({tag, "_ready_done"}, ready8, 1);
        tick();
        check({tag, "_valid_pulse"}, valid8, 0);
        check({tag, "_res_hold"}, result8, er);
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;
        check("rst_ready", ready8, 1);
        check("rst_valid", valid8, 0);
        check("rst_res", result8, 0);
        check("rst_flags", {z8, n8, h8, c8}, 0);
        check("rst_ready16", ready16, 1);

        //   tag     op    a      b      cin   result  ZNHC
        run8("add",  3'd0, 8'h3A, 8'hC6, 1'b0, 8'h00, 4'b1011);
        run8("sub",  3'd2, 8'h10, 8'h01, 1'b0, 8'h0F, 4'b0110);
        run8("sbc",  3'd3, 8'h00, 8'h00, 1'b1, 8'hFF, 4'b0111);
        run8("adc",  3'd1, 8'hFF, 8'h00, 1'b1, 8'h00, 4'b1011);
        run8("add_h", 3'd0, 8'h08, 8'h08, 1'b1, 8'h10, 4'b0010);
        run8("and",  3'd4, 8'hF0, 8'h0F, 1'b1, 8'h00, 4'b1010);
        run8("xor",  3'd5, 8'h5A, 8'hFF, 1'b1, 8'hA5, 4'b0000);
        run8("or",   3'd6, 8'h00, 8'h00, 1'b0, 8'h00, 4'b1000);
        run8("cp",   3'd7, 8'h42, 8'h42, 1'b0, 8'h42, 4'b1100);

        // Reset one cycle after accept: the op is dropped and state clears.
        op = 3'd0; a8 = 8'h01; b8 = 8'h01; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_ready", ready8, 1);
        check("abort_valid", valid8, 0);
        check("abort_res", result8, 0);
        check("abort_flags", {z8, n8, h8, c8}, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_no_valid", valid8, 0);
        end

        // Back-to-back: start held through RUN (ignored) and DONE (accepted).
        op = 3'd0; a8 = 8'h01; b8 = 8'h02; start8 = 1'b1;
        tick();
        check("b2b_ready_run", ready8, 0);
        a8 = 8'h10; b8 = 8'h20;
        tick();
        check("b2b_valid_early", valid8, 0);
        tick();
        check("b2b_valid1", valid8, 1);
        check("b2b_res1", result8, 8'h03);
        check("b2b_ready_done", ready8, 1);
        tick();
        start8 = 1'b0;
        check("b2b_valid_gap", valid8, 0);
        check("b2b_accept_done", ready8, 0);
        tick();
        check("b2b_valid_gap2", valid8, 0);
        tick();
        check("b2b_valid2", valid8, 1);
        check("b2b_res2", result8, 8'h30);
        tick();
        check("b2b_end", valid8, 0);
        check("b2b_idle", ready8, 1);

        // 16-bit word: four passes, valid on the fourth edge after accept.
        op = 3'd0; carry_in = 1'b0; a16 = 16'hFFFF; b16 = 16'h0001; start16 = 1'b1;
        tick();
        start16 = 1'b0;
        for (int i = 1; i < 4; i++) begin
            check("w16_ready_run", ready16, 0);
            tick();
            check("w16_valid_early", valid16, 0);
        end
        tick();
        check("w16_valid", valid16, 1);
        check("w16_res", result16, 16'h0000);
        check("w16_znhc", {z16, n16, h16, c16}, 4'b1011);
        tick();
        check("w16_valid_pulse", valid16, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/sm83_alu_seq.md
Name: sm83_alu_seq

Overview:
Multi-cycle, parametrised successor to the CPU's 4-bit-slice ALU core. It performs a full WORD_SIZE-bit operation as a sequence of ALU_WIDTH-bit slice passes, LSB slice first. Carry ripples between passes through an internal register. It has a start/ready/valid handshake and produces SM83-style Z/N/H/C flags. It sits beside the existing ALU and serves wide operations (16-bit ADD HL/SP arithmetic, wider experimental datapaths).

Parameters:
ALU_WIDTH, 4, slice width in bits processed per pass.
WORD_SIZE, 8, operand/result width; must be an integer multiple of ALU_WIDTH and at least 2*ALU_WIDTH.
PASSES (localparam), WORD_SIZE/ALU_WIDTH, number of slice passes per operation.

Ports:
clk  input  1  clock; all state updates on posedge.
reset  input  1  synchronous, active-high reset.
start  input  1  request; accepted when start && ready at a posedge.
op  input  3  operation: 0 ADD, 1 ADC, 2 SUB, 3 SBC, 4 AND, 5 XOR, 6 OR, 7 CP.
a  input  WORD_SIZE  operand A; sampled only on accept.
b  input  WORD_SIZE  operand B; sampled only on accept.
carry_in  input  1  incoming C flag, used by ADC/SBC; sampled on accept.
ready  output  1  high when a new start can be accepted.
valid  output  1  one-cycle pulse: result and flags are updated.
result  output  WORD_SIZE  operation result; holds until the next valid.
flag_z  output  1  result (arithmetic difference for CP) equals zero.
flag_n  output  1  subtract flag.
flag_h  output  1  carry/borrow out of slice 0 (bit ALU_WIDTH-1).
flag_c  output  1  carry/borrow out of the MSB.

Behaviour:
- Reset (synchronous, any state including mid-operation):
  - state goes to IDLE.
  - result=0, all flags=0, valid=0, ready=1 from the next cycle.
  - An aborted operation never produces valid.
- States are IDLE, RUN, DONE.
  - ready=1 in IDLE and DONE; ready=0 in RUN.
- Accept:
  - On a start && ready posedge, latch a, b, op and the effective carry, clear the pass counter, and go to RUN.
  - Effective carry is: ADD=0, ADC=carry_in, SUB/CP=1, SBC=!carry_in.
  - start while in RUN is ignored. It is not queued.
- RUN, one slice per cycle (pass k = 0..PASSES-1):
  - Operand bits are a[k*ALU_WIDTH +: ALU_WIDTH] and b slice k.
  - b is inverted for SUB/SBC/CP.
  - The slice sum goes to the internal result register, and the slice carry-out goes to the carry register.
  - After pass 0, capture the carry-out as raw H.
  - After pass PASSES-1, go to DONE. Result, flags and valid are registered on that same edge.
- Latency: start accepted at edge E0; passes at edges E1..E_PASSES; valid=1 for exactly the cycle following E_PASSES. For 8/4 that is 2 cycles after accept.
- DONE lasts one cycle.
  - If start is asserted, it is accepted (back-to-back throughput of one op per PASSES+1 cycles) and the state goes to RUN.
  - Otherwise the state goes to IDLE.
- Logic ops (AND/XOR/OR) use the same per-slice sequencing with no carry chain.
- Flags:
  - ADD/ADC: N=0, H=raw H, C=final carry.
  - SUB/SBC/CP: N=1, H=!raw H, C=!final carry (borrow).
  - AND: N=0, H=1, C=0.
  - XOR/OR: N=0, H=0, C=0.
  - Z is computed over the full WORD_SIZE result for all ops.
- CP: result output equals latched a (unchanged); flags come from the subtraction.
- Arithmetic is modulo 2^WORD_SIZE; no overflow flag.
- result and flags change only on the edge that raises valid, or on reset.

Test Plan:
- Reset, then ADD a=0x3A b=0xC6 (8/4) -> valid in the 2nd cycle after accept; result=0x00, Z=1 N=0 H=1 C=1; ready=0 during RUN.
- SUB 0x10-0x01 -> result=0x0F, Z=0 N=1 H=1 C=0.
- SBC a=0x00 b=0x00 carry_in=1 -> result=0xFF, Z=0 N=1 H=1 C=1. Then ADC 0xFF+0x00 carry_in=1 -> 0x00, Z=1 H=1 C=1.
- AND 0xF0&0x0F -> 0x00, Z=1 H=1 C=0. CP a=0x42 b=0x42 -> result=0x42, Z=1 N=1 H=0 C=0.
- Back-to-back: start held high through DONE -> second op accepted in the DONE cycle; start pulses during RUN are ignored; exactly one valid per accepted op.
- Reset asserted one cycle after accept -> no valid ever; result/flags read 0, ready=1. Then WORD_SIZE=16 ADD 0xFFFF+0x0001 -> result=0x0000, Z=1 H=1 C=1, valid 4 cycles after accept.
